// File: rtl/histogram_frame_ctrl.sv
// Frame sequencer for a histogram_compressor: accepts a bit-pair frame, clears the
// datapath, serialises the frame LSB first, then captures and returns the four joint counts.
module histogram_frame_ctrl #(
  parameter int STREAM_LENGTH = 128,
  parameter int COUNTER_WIDTH = $clog2(STREAM_LENGTH + 1),
  parameter int CLR_CYCLES    = 2,
  parameter int DRAIN_CYCLES  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [STREAM_LENGTH-1:0] in_a,
  input  logic [STREAM_LENGTH-1:0] in_b,
  output logic                     hist_clr_n,
  output logic                     hist_stream_a,
  output logic                     hist_stream_b,
  output logic                     hist_valid_in,
  input  logic [COUNTER_WIDTH-1:0] hist_count_00,
  input  logic [COUNTER_WIDTH-1:0] hist_count_01,
  input  logic [COUNTER_WIDTH-1:0] hist_count_10,
  input  logic [COUNTER_WIDTH-1:0] hist_count_11,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [COUNTER_WIDTH-1:0] out_count_00,
  output logic [COUNTER_WIDTH-1:0] out_count_01,
  output logic [COUNTER_WIDTH-1:0] out_count_10,
  output logic [COUNTER_WIDTH-1:0] out_count_11,
  output logic                     out_err,
  output logic                     busy
);

  localparam int MAX_A = (STREAM_LENGTH > CLR_CYCLES) ? STREAM_LENGTH : CLR_CYCLES;
  localparam int MAX_C = (MAX_A > DRAIN_CYCLES) ? MAX_A : DRAIN_CYCLES;
  localparam int CNTW  = $clog2(MAX_C + 1);
  localparam int SUMW  = COUNTER_WIDTH + 2;

  localparam logic [CNTW-1:0] CLR_LAST   = CNTW'(CLR_CYCLES - 1);
  localparam logic [CNTW-1:0] FEED_LAST  = CNTW'(STREAM_LENGTH - 1);
  localparam logic [CNTW-1:0] DRAIN_LAST = CNTW'(DRAIN_CYCLES - 1);
  localparam logic [SUMW-1:0] SUM_EXP    = SUMW'(STREAM_LENGTH);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, CAPTURE, DONE} state_e;

  state_e                   state_q, state_d;
  logic [CNTW-1:0]          cnt_q, cnt_d;
  logic [STREAM_LENGTH-1:0] sha_q, sha_d, shb_q, shb_d;
  logic [SUMW-1:0]          sum;

  logic                     in_ready_q, hist_clr_n_q, hist_valid_q, hist_a_q, hist_b_q;
  logic                     out_valid_q, out_err_q, busy_q;
  logic [COUNTER_WIDTH-1:0] c00_q, c01_q, c10_q, c11_q;

  assign sum = SUMW'(hist_count_00) + SUMW'(hist_count_01)
             + SUMW'(hist_count_10) + SUMW'(hist_count_11);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    unique case (state_q)
      IDLE: if (in_valid && in_ready_q) begin
        sha_d   = in_a;
        shb_d   = in_b;
        cnt_d   = '0;
        state_d = CLEAR;
      end
      CLEAR: if (cnt_q == CLR_LAST) begin
        cnt_d   = '0;
        state_d = FEED;
      end else cnt_d = cnt_q + CNTW'(1);
      FEED: if (cnt_q == FEED_LAST) begin
        cnt_d   = '0;
        state_d = DRAIN;
      end else cnt_d = cnt_q + CNTW'(1);
      DRAIN: if (cnt_q == DRAIN_LAST) begin
        cnt_d   = '0;
        state_d = CAPTURE;
      end else cnt_d = cnt_q + CNTW'(1);
      CAPTURE: state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state, so the bit leaving the shifter
    // on each edge entering/staying in FEED is the one the compressor sees that cycle.
    if (state_d == FEED) begin
      sha_d = sha_q >> 1;
      shb_d = shb_q >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sha_q        <= '0;
      shb_q        <= '0;
      in_ready_q   <= 1'b0;
      hist_clr_n_q <= 1'b0;
      hist_valid_q <= 1'b0;
      hist_a_q     <= 1'b0;
      hist_b_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      c00_q        <= '0;
      c01_q        <= '0;
      c10_q        <= '0;
      c11_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sha_q        <= sha_d;
      shb_q        <= shb_d;
      in_ready_q   <= (state_d == IDLE);
      hist_clr_n_q <= (state_d != CLEAR);
      hist_valid_q <= (state_d == FEED);
      hist_a_q     <= (state_d == FEED) ? sha_q[0] : 1'b0;
      hist_b_q     <= (state_d == FEED) ? shb_q[0] : 1'b0;
      out_valid_q  <= (state_d == DONE);
      busy_q       <= (state_d != IDLE);
      if (state_q == CAPTURE) begin
        c00_q     <= hist_count_00;
        c01_q     <= hist_count_01;
        c10_q     <= hist_count_10;
        c11_q     <= hist_count_11;
        out_err_q <= (sum != SUM_EXP);
      end
    end
  end

  assign in_ready      = in_ready_q;
  assign hist_clr_n    = hist_clr_n_q;
  assign hist_valid_in = hist_valid_q;
  assign hist_stream_a = hist_a_q;
  assign hist_stream_b = hist_b_q;
  assign out_valid     = out_valid_q;
  assign out_err       = out_err_q;
  assign busy          = busy_q;
  assign out_count_00  = c00_q;
  assign out_count_01  = c01_q;
  assign out_count_10  = c10_q;
  assign out_count_11  = c11_q;

endmodule

// File: tb/tb_histogram_frame_ctrl.sv
// Bench for histogram_frame_ctrl: behavioural compressor partner plus a per-frame
// software histogram reference; directed and $urandom frames.
module tb_histogram_frame_ctrl;
  localparam int SL  = 128;
  localparam int CW  = $clog2(SL + 1);
  localparam int LAT = 2 + SL + 1 + 1;

  logic          clk, rst_n, in_valid, in_ready, out_valid, out_ready, out_err, busy;
  logic [SL-1:0] in_a, in_b;
  logic          hist_clr_n, hist_stream_a, hist_stream_b, hist_valid_in;
  logic [CW-1:0] hist_count_00, hist_count_01, hist_count_10, hist_count_11;
  logic [CW-1:0] out_count_00, out_count_01, out_count_10, out_count_11;

  int n_cmp = 0, n_bad = 0, cyc = 0, acc_cyc = 0, run = 0, last_run = 0, bias = 0;
  int e[4];
  int exp_err;
  logic [CW-1:0] m[4];

  histogram_frame_ctrl #(.STREAM_LENGTH(SL), .COUNTER_WIDTH(CW), .CLR_CYCLES(2), .DRAIN_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .hist_clr_n(hist_clr_n), .hist_stream_a(hist_stream_a), .hist_stream_b(hist_stream_b),
    .hist_valid_in(hist_valid_in), .hist_count_00(hist_count_00), .hist_count_01(hist_count_01),
    .hist_count_10(hist_count_10), .hist_count_11(hist_count_11), .out_valid(out_valid),
    .out_ready(out_ready), .out_count_00(out_count_00), .out_count_01(out_count_01),
    .out_count_10(out_count_10), .out_count_11(out_count_11), .out_err(out_err), .busy(busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Compressor partner: joint counts indexed {a,b}, cleared while hist_clr_n is low.
  always @(posedge clk or negedge hist_clr_n) begin
    if (!hist_clr_n) begin
      for (int i = 0; i < 4; i++) m[i] <= '0;
    end else if (hist_valid_in) begin
      m[{hist_stream_a, hist_stream_b}] <= m[{hist_stream_a, hist_stream_b}] + CW'(1);
    end
  end
  assign hist_count_00 = m[0];
  assign hist_count_01 = m[1];
  assign hist_count_10 = m[2];
  assign hist_count_11 = m[3] + CW'(bias);

  // Length of the most recent unbroken hist_valid_in burst.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) run = 0;
    else if (hist_valid_in) run = run + 1;
    else if (run != 0) begin
      last_run = run;
      run = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_model(input logic [SL-1:0] a, input logic [SL-1:0] b);
    int s;
    for (int i = 0; i < 4; i++) e[i] = 0;
    for (int k = 0; k < SL; k++) e[{a[k], b[k]}]++;
    e[3] += bias;
    s = e[0] + e[1] + e[2] + e[3];
    exp_err = (s != SL) ? 1 : 0;
  endtask

  function automatic logic [SL-1:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic accept(input logic [SL-1:0] a, input logic [SL-1:0] b);
    int t = 0;
    set_model(a, b);
    while (!in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    @(negedge clk);
    acc_cyc = cyc;
    in_valid = 1'b0;
    in_a = rnd();
    in_b = rnd();
  endtask

  task automatic collect(input string tag);
    int t = 0;
    while (!out_valid && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) chk({tag, "_timeout"}, 0, 1);
    chk({tag, "_latency"}, cyc - acc_cyc, LAT);
    chk({tag, "_c00"}, 32'(out_count_00), e[0]);
    chk({tag, "_c01"}, 32'(out_count_01), e[1]);
    chk({tag, "_c10"}, 32'(out_count_10), e[2]);
    chk({tag, "_c11"}, 32'(out_count_11), e[3]);
    chk({tag, "_err"}, 32'(out_err), exp_err);
    chk({tag, "_burst"}, last_run, SL);
    last_run = 0;
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_valid_drop"}, 32'(out_valid), 0);
    chk({tag, "_ready_idle"}, 32'(in_ready), 1);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [SL-1:0] a, b;
    logic [CW-1:0] s00, s01, s10, s11;
    logic          serr;
    int            bad, t;

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_clr_n", 32'(hist_clr_n), 0);
    chk("rst_hist_valid", 32'(hist_valid_in), 0);
    chk("rst_streams", {30'd0, hist_stream_a, hist_stream_b}, 0);
    chk("rst_counts", {out_count_00, out_count_01, out_count_10, out_count_11}, 0);
    chk("rst_err", 32'(out_err), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_clr_n", 32'(hist_clr_n), 1);

    // A all zero, B all one
    accept('0, '1);
    collect("t1");
    release_out("t1");

    // Back-to-back with out_ready tied high: no residue from the first frame
    out_ready = 1'b1;
    accept('1, '1);
    collect("t2a");
    release_out("t2a");
    out_ready = 1'b1;
    accept('0, '0);
    collect("t2b");
    release_out("t2b");

    // Alternating patterns
    for (int k = 0; k < SL; k++) begin
      a[k] = k[0];
      b[k] = ~k[0];
    end
    accept(a, b);
    collect("t3");
    release_out("t3");

    // Back-pressure in DONE with a pending frame
    accept(rnd(), rnd());
    collect("t4");
    s00 = out_count_00; s01 = out_count_01; s10 = out_count_10; s11 = out_count_11; serr = out_err;
    a = rnd();
    b = rnd();
    in_a = a; in_b = b; in_valid = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!out_valid || in_ready || !busy || out_count_00 !== s00 || out_count_01 !== s01 ||
          out_count_10 !== s10 || out_count_11 !== s11 || out_err !== serr) bad++;
    end
    chk("t4_hold_violations", bad, 0);
    set_model(a, b);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t4_valid_drop", 32'(out_valid), 0);
    chk("t4_ready_idle", 32'(in_ready), 1);
    out_ready = 1'b0;
    @(negedge clk);
    acc_cyc = cyc;
    in_valid = 1'b0;
    chk("t4_accepted_busy", 32'(busy), 1);
    chk("t4_accepted_ready", 32'(in_ready), 0);
    collect("t4b");
    release_out("t4b");

    // Reset part-way through FEED
    accept(rnd(), rnd());
    t = 0;
    while (run < 50 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("t5_reached_bit50", (run >= 50) ? 1 : 0, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_hist_valid", 32'(hist_valid_in), 0);
    chk("t5_clr_n", 32'(hist_clr_n), 0);
    chk("t5_streams", {30'd0, hist_stream_a, hist_stream_b}, 0);
    chk("t5_out_valid", 32'(out_valid), 0);
    chk("t5_in_ready", 32'(in_ready), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_run = 0;
    accept(rnd(), rnd());
    collect("t5");
    release_out("t5");

    // Corrupted count_11 from the partner: error flag, values passed through
    bias = 1;
    accept(rnd(), rnd());
    collect("t6");
    release_out("t6");
    bias = 0;

    for (int i = 0; i < 3; i++) begin
      accept(rnd(), rnd());
      collect("rand");
      release_out("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
